integrator_peak_finder: RTL and testbench

- Consumer at the far end of the gated integrator's sum/valid output stream.
- Watches the windowed sum for threshold crossings and tracks each pulse while it stays above threshold.
- Emits one event record per pulse: peak sum, peak timestamp and width, through a single-entry ready/valid output register.
- Sits between the integrator and the event readout/FIFO logic.

---
 rtl/integrator_peak_finder_evt_hold_reg.sv | 48 ++++
 rtl/integrator_peak_finder.sv | 110 +++++++++++
 tb/tb_integrator_peak_finder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/integrator_peak_finder_evt_hold_reg.sv
// Single-entry ready/valid holding register for event records.
// A record offered while the register is full and not being drained is lost and counted.
module evt_hold_reg #(
  parameter int P_NBITS_REC  = 60,
  parameter int P_NBITS_DROP = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [P_NBITS_REC-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [P_NBITS_REC-1:0]  out_data,
  output logic [P_NBITS_DROP-1:0] drop_cnt
);

  localparam logic [P_NBITS_DROP-1:0] DROP_ONE = 1;

  logic                    valid_reg;
  logic [P_NBITS_REC-1:0]  data_reg;
  logic [P_NBITS_DROP-1:0] drop_reg;
  logic                    accept;

  assign accept = valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      drop_reg  <= '0;
    end else if (in_valid) begin
      // A slot freed in the same cycle is reused immediately.
      if (!valid_reg || accept) begin
        valid_reg <= 1'b1;
        data_reg  <= in_data;
      end else if (drop_reg != '1) begin
        drop_reg <= drop_reg + DROP_ONE;
      end
    end else if (accept) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign drop_cnt  = drop_reg;

endmodule

// File: rtl/integrator_peak_finder.sv
// Threshold-crossing pulse tracker on the integrator sum stream; emits one
// {peak, peak time, width} record per pulse followed by a programmable dead time.
module integrator_peak_finder #(
  parameter int P_NBITS_DATA  = 20,
  parameter int P_NBITS_TIME  = 32,
  parameter int P_NBITS_WIDTH = 8,
  parameter int P_NBITS_DROP  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [P_NBITS_DATA-1:0]  thresh,
  input  logic [P_NBITS_WIDTH-1:0] holdoff,
  input  logic [P_NBITS_DATA-1:0]  sum_in,
  input  logic                     sum_valid,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [P_NBITS_DATA-1:0]  evt_peak,
  output logic [P_NBITS_TIME-1:0]  evt_time,
  output logic [P_NBITS_WIDTH-1:0] evt_width,
  output logic [P_NBITS_DROP-1:0]  drop_cnt,
  output logic                     busy
);

  localparam int P_NBITS_REC = P_NBITS_DATA + P_NBITS_TIME + P_NBITS_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ABOVE   = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  localparam logic [P_NBITS_TIME-1:0]  TS_ONE = 1;
  localparam logic [P_NBITS_WIDTH-1:0] W_ONE  = 1;

  logic [1:0]               state_reg;
  logic [P_NBITS_TIME-1:0]  ts_reg;
  logic [P_NBITS_DATA-1:0]  peak_reg;
  logic [P_NBITS_TIME-1:0]  ptime_reg;
  logic [P_NBITS_WIDTH-1:0] width_reg;
  logic [P_NBITS_WIDTH-1:0] hcnt_reg;
  logic                     above;
  logic                     emit;
  logic [P_NBITS_REC-1:0]   rec_out;

  assign above = sum_in >= thresh;
  assign emit  = (state_reg == S_ABOVE) && sum_valid && !above;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      ts_reg    <= '0;
      peak_reg  <= '0;
      ptime_reg <= '0;
      width_reg <= '0;
      hcnt_reg  <= '0;
    end else begin
      ts_reg <= ts_reg + TS_ONE;
      case (state_reg)
        S_IDLE: begin
          if (sum_valid && above) begin
            peak_reg  <= sum_in;
            ptime_reg <= ts_reg;
            width_reg <= W_ONE;
            state_reg <= S_ABOVE;
          end
        end
        S_ABOVE: begin
          if (sum_valid) begin
            if (above) begin
              if (width_reg != '1)
                width_reg <= width_reg + W_ONE;
              // Strict compare so a repeated maximum keeps its first timestamp.
              if (sum_in > peak_reg) begin
                peak_reg  <= sum_in;
                ptime_reg <= ts_reg;
              end
            end else if (holdoff == '0) begin
              state_reg <= S_IDLE;
            end else begin
              hcnt_reg  <= holdoff;
              state_reg <= S_HOLDOFF;
            end
          end
        end
        S_HOLDOFF: begin
          hcnt_reg <= hcnt_reg - W_ONE;
          if (hcnt_reg <= W_ONE)
            state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  evt_hold_reg #(
    .P_NBITS_REC (P_NBITS_REC),
    .P_NBITS_DROP(P_NBITS_DROP)
  ) u_evt_hold_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (emit),
    .in_data  ({peak_reg, ptime_reg, width_reg}),
    .out_valid(evt_valid),
    .out_ready(evt_ready),
    .out_data (rec_out),
    .drop_cnt (drop_cnt)
  );

  assign {evt_peak, evt_time, evt_width} = rec_out;
  assign busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_integrator_peak_finder.sv
// Directed bench for integrator_peak_finder: a per-cycle vector table for the
// basic pulse shapes plus hand-written sequences for holdoff, backpressure and reset.
module tb_integrator_peak_finder;

  localparam int DW = 20;
  localparam int TW = 32;
  localparam int WW = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] thresh;
  logic [WW-1:0] holdoff;
  logic [DW-1:0] sum_in;
  logic          sum_valid;
  logic          evt_valid;
  logic          evt_ready;
  logic [DW-1:0] evt_peak;
  logic [TW-1:0] evt_time;
  logic [WW-1:0] evt_width;
  logic [PW-1:0] drop_cnt;
  logic          busy;

  integrator_peak_finder #(
    .P_NBITS_DATA (DW),
    .P_NBITS_TIME (TW),
    .P_NBITS_WIDTH(WW),
    .P_NBITS_DROP (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .thresh   (thresh),
    .holdoff  (holdoff),
    .sum_in   (sum_in),
    .sum_valid(sum_valid),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_peak (evt_peak),
    .evt_time (evt_time),
    .evt_width(evt_width),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit            rst_first;
    bit            v;
    logic [DW-1:0] s;
    bit            busy;
    bit            ev;
    logic [DW-1:0] peak;
    logic [TW-1:0] tm;
    logic [WW-1:0] w;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one input sample for a cycle; return just after the edge that samples it.
  task automatic cyc(input logic v, input logic [DW-1:0] s);
    sum_valid = v;
    sum_in    = s;
    @(posedge clk);
    #1;
  endtask

  // After return, the current cycle has ts == 0.
  task automatic do_reset();
    rst       = 1'b1;
    sum_valid = 1'b0;
    sum_in    = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_evt(input string tag, input bit ev, input logic [DW-1:0] pk,
                         input logic [TW-1:0] tm, input logic [WW-1:0] w);
    chk({tag, ".evt_valid"}, 64'(evt_valid), 64'(ev));
    if (ev) begin
      chk({tag, ".evt_peak"}, 64'(evt_peak), 64'(pk));
      chk({tag, ".evt_time"}, 64'(evt_time), 64'(tm));
      chk({tag, ".evt_width"}, 64'(evt_width), 64'(w));
    end
  endtask

  initial begin
    rst       = 1'b1;
    thresh    = 20'd100;
    holdoff   = '0;
    sum_in    = '0;
    sum_valid = 1'b0;
    evt_ready = 1'b1;

    // Pulse 50,120,180,180,90 back to back: peak 180 at ts 2, width 3.
    tbl[0]  = '{1, 1, 50,  0, 0, 0,   0, 0};
    tbl[1]  = '{0, 1, 120, 1, 0, 0,   0, 0};
    tbl[2]  = '{0, 1, 180, 1, 0, 0,   0, 0};
    tbl[3]  = '{0, 1, 180, 1, 0, 0,   0, 0};
    tbl[4]  = '{0, 1, 90,  0, 1, 180, 2, 3};
    tbl[5]  = '{0, 0, 0,   0, 0, 0,   0, 0};
    // Same pulse with 2-cycle sum_valid gaps carrying an ignored large value.
    tbl[6]  = '{1, 1, 50,  0, 0, 0,   0, 0};
    tbl[7]  = '{0, 0, 999, 0, 0, 0,   0, 0};
    tbl[8]  = '{0, 0, 999, 0, 0, 0,   0, 0};
    tbl[9]  = '{0, 1, 120, 1, 0, 0,   0, 0};
    tbl[10] = '{0, 0, 999, 1, 0, 0,   0, 0};
    tbl[11] = '{0, 0, 999, 1, 0, 0,   0, 0};
    tbl[12] = '{0, 1, 180, 1, 0, 0,   0, 0};
    tbl[13] = '{0, 0, 999, 1, 0, 0,   0, 0};
    tbl[14] = '{0, 0, 999, 1, 0, 0,   0, 0};
    tbl[15] = '{0, 1, 180, 1, 0, 0,   0, 0};
    tbl[16] = '{0, 0, 5,   1, 0, 0,   0, 0};
    tbl[17] = '{0, 0, 5,   1, 0, 0,   0, 0};
    tbl[18] = '{0, 1, 90,  0, 1, 180, 6, 3};
    tbl[19] = '{0, 0, 0,   0, 0, 0,   0, 0};

    do_reset();
    chk("reset.evt_valid", 64'(evt_valid), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.drop_cnt", 64'(drop_cnt), 64'd0);
    chk("reset.evt_peak", 64'(evt_peak), 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].rst_first) do_reset();
      cyc(tbl[i].v, tbl[i].s);
      $display("vec %0d: v=%0d sum=%0d -> busy=%0d evt_valid=%0d peak=%0d time=%0d width=%0d",
               i, tbl[i].v, tbl[i].s, busy, evt_valid, evt_peak, evt_time, evt_width);
      chk($sformatf("vec%0d.busy", i), 64'(busy), 64'(tbl[i].busy));
      chk_evt($sformatf("vec%0d", i), tbl[i].ev, tbl[i].peak, tbl[i].tm, tbl[i].w);
      chk($sformatf("vec%0d.drop_cnt", i), 64'(drop_cnt), 64'd0);
    end

    // Holdoff of 5: sample 3 cycles after the end is ignored, 6 cycles after starts a pulse.
    holdoff = 8'd5;
    do_reset();
    cyc(1, 150);                                   // ts0
    cyc(1, 50);                                    // ts1 ends pulse
    $display("hold: end of pulse busy=%0d evt_valid=%0d", busy, evt_valid);
    chk("hold.busy_after_end", 64'(busy), 64'd1);
    chk_evt("hold.evt1", 1, 150, 0, 1);
    cyc(0, 0);                                     // ts2
    chk("hold.accepted", 64'(evt_valid), 64'd0);
    cyc(0, 0);                                     // ts3
    cyc(1, 200);                                   // ts4, inside holdoff
    chk("hold.ignored_busy", 64'(busy), 64'd1);
    cyc(0, 0);                                     // ts5
    chk("hold.still_busy", 64'(busy), 64'd1);
    cyc(0, 0);                                     // ts6, last holdoff cycle
    chk("hold.idle_after5", 64'(busy), 64'd0);
    chk("hold.no_event", 64'(evt_valid), 64'd0);
    cyc(1, 130);                                   // ts7 new pulse
    chk("hold.new_pulse_busy", 64'(busy), 64'd1);
    cyc(1, 40);                                    // ts8
    $display("hold: second event peak=%0d time=%0d", evt_peak, evt_time);
    chk_evt("hold.evt2", 1, 130, 7, 1);
    holdoff = 8'd0;

    // Backpressure: second event dropped while the first is held.
    evt_ready = 1'b0;
    do_reset();
    cyc(1, 150);                                   // ts0
    cyc(1, 50);                                    // ts1
    chk_evt("bp.first", 1, 150, 0, 1);
    cyc(1, 200);                                   // ts2
    cyc(1, 210);                                   // ts3
    cyc(1, 10);                                    // ts4 second pulse ends
    $display("bp: held peak=%0d drop_cnt=%0d", evt_peak, drop_cnt);
    chk_evt("bp.held", 1, 150, 0, 1);
    chk("bp.drop_cnt", 64'(drop_cnt), 64'd1);
    evt_ready = 1'b1;
    cyc(0, 0);
    chk("bp.released", 64'(evt_valid), 64'd0);
    chk("bp.drop_kept", 64'(drop_cnt), 64'd1);

    // Accept and emit on the same edge: new record replaces, no drop.
    evt_ready = 1'b0;
    do_reset();
    cyc(1, 150);                                   // ts0
    cyc(1, 50);                                    // ts1
    cyc(1, 300);                                   // ts2
    evt_ready = 1'b1;
    cyc(1, 20);                                    // ts3 ends, accepted same edge
    evt_ready = 1'b0;
    $display("swap: peak=%0d time=%0d drop_cnt=%0d", evt_peak, evt_time, drop_cnt);
    chk_evt("swap.new", 1, 300, 2, 1);
    chk("swap.drop_cnt", 64'(drop_cnt), 64'd0);
    cyc(0, 0);
    chk_evt("swap.stable", 1, 300, 2, 1);
    evt_ready = 1'b1;
    cyc(0, 0);
    chk("swap.drained", 64'(evt_valid), 64'd0);

    // Reset mid-pulse with a pending event and a nonzero drop count.
    evt_ready = 1'b0;
    do_reset();
    cyc(1, 150);                                   // ts0
    cyc(1, 50);                                    // ts1 pending
    cyc(1, 200);                                   // ts2
    cyc(1, 10);                                    // ts3 dropped
    cyc(1, 250);                                   // ts4 in ABOVE
    chk("rst.pre_drop", 64'(drop_cnt), 64'd1);
    chk("rst.pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    cyc(1, 250);
    rst = 1'b0;
    evt_ready = 1'b1;
    $display("rst: evt_valid=%0d busy=%0d drop_cnt=%0d", evt_valid, busy, drop_cnt);
    chk("rst.evt_valid", 64'(evt_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.drop_cnt", 64'(drop_cnt), 64'd0);
    cyc(1, 10);                                    // ts0 below: old pulse must not end
    chk("rst.no_old_event", 64'(evt_valid), 64'd0);
    cyc(1, 180);                                   // ts1
    cyc(1, 10);                                    // ts2
    chk_evt("rst.after", 1, 180, 1, 1);

    // Width saturates at all-ones for a long pulse.
    do_reset();
    for (int k = 0; k < 300; k++) cyc(1, 150);
    chk("sat.busy", 64'(busy), 64'd1);
    cyc(1, 50);
    $display("sat: width=%0d", evt_width);
    chk_evt("sat", 1, 150, 0, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
